// File: rtl/seven_seg_scanner.sv
// Four-digit time-multiplexed driver for a common-anode 7-segment display.
// Display words are double-buffered and committed only at frame boundaries.
module seven_seg_scanner #(
   parameter int DIGIT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value,
   input  logic        load,
   input  logic        blank_lz,
   input  logic        enable,
   output logic [3:0]  hex,
   output logic [3:0]  an,
   output logic        frame_done
);

   localparam int               CNT_W   = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [15:0]      shadow_q, shadow_d;
   logic [15:0]      pending_q, pending_d;
   logic             pend_v_q, pend_v_d;
   logic             frame_done_q, frame_done_d;

   logic             digit_wrap;
   logic             frame_end;

   assign digit_wrap = (cnt_q == CNT_MAX);
   assign frame_end  = digit_wrap && (idx_q == 2'd3);

   always_comb begin
      // NOTE: every target gets a default first, so no path through this block
      // leaves a signal unassigned and no latch is inferred.
      cnt_d        = cnt_q + 1'b1;
      idx_d        = idx_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      pend_v_d     = pend_v_q;
      frame_done_d = frame_end;

      if (digit_wrap) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end

      // A load on the boundary edge bypasses the pending buffer entirely.
      if (frame_end) begin
         pend_v_d = 1'b0;
         if (load) begin
            shadow_d = value;
         end else if (pend_v_q) begin
            shadow_d = pending_q;
         end
      end else if (load) begin
         pending_d = value;
         pend_v_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop updates from the same
      // pre-edge values regardless of statement order.
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         pending_q    <= '0;
         pend_v_q     <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         pend_v_q     <= pend_v_d;
         frame_done_q <= frame_done_d;
      end
   end

   logic [3:0] cur_nib;
   logic       zero_from3, zero_from2, zero_from1;
   logic       blanked;

   always_comb begin
      cur_nib    = shadow_q[{idx_q, 2'b00} +: 4];
      zero_from3 = (shadow_q[15:12] == 4'h0);
      zero_from2 = zero_from3 && (shadow_q[11:8] == 4'h0);
      zero_from1 = zero_from2 && (shadow_q[7:4] == 4'h0);

      // Digit0 is never blanked, so an all-zero word still shows one "0".
      case (idx_q)
         2'd1:    blanked = blank_lz && zero_from1;
         2'd2:    blanked = blank_lz && zero_from2;
         2'd3:    blanked = blank_lz && zero_from3;
         default: blanked = 1'b0;
      endcase

      an  = 4'b1111;
      hex = cur_nib;
      if (blanked) begin
         hex = 4'h0;
      end else if (enable) begin
         an = ~(4'b0001 << idx_q);
      end
   end

   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: a frame-position model predicts
// an/hex/frame_done, predictions are queued on drive and checked on output.
module tb_seven_seg_scanner;

   localparam int DC    = 4;
   localparam int FRAME = 4 * DC;

   logic        clk;
   logic        reset;
   logic [15:0] value;
   logic        load;
   logic        blank_lz;
   logic        enable;
   logic [3:0]  hex;
   logic [3:0]  an;
   logic        frame_done;

   seven_seg_scanner #(.DIGIT_CYCLES(DC)) dut (
      .clk        (clk),
      .reset      (reset),
      .value      (value),
      .load       (load),
      .blank_lz   (blank_lz),
      .enable     (enable),
      .hex        (hex),
      .an         (an),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] hex;
      logic       fd;
   } exp_t;

   exp_t exp_q[$];

   int vectors     = 0;
   int miscompares = 0;
   int cycle_no    = 0;

   // Reference model: position within the frame plus displayed/pending words.
   int          m_pos    = 0;
   logic [15:0] m_shadow = '0;
   logic [15:0] m_pend   = '0;
   logic        m_pend_v = 1'b0;
   logic        m_fd     = 1'b0;

   function automatic exp_t model_out();
      exp_t        e;
      int          d;
      logic [15:0] upper;
      logic        blk;
      d     = m_pos / DC;
      upper = m_shadow >> (4 * d);
      blk   = blank_lz && (d != 0) && (upper == 16'h0000);
      e.fd  = m_fd;
      e.hex = blk ? 4'h0 : upper[3:0];
      if (blk || !enable) e.an = 4'b1111;
      else                e.an = ~(4'b0001 << d);
      return e;
   endfunction

   task automatic model_edge(input logic rst_i, input logic ld_i, input logic [15:0] v_i);
      logic last;
      last = (m_pos == FRAME - 1);
      if (rst_i) begin
         m_pos    = 0;
         m_shadow = '0;
         m_pend   = '0;
         m_pend_v = 1'b0;
         m_fd     = 1'b0;
      end else begin
         m_fd = last;
         if (last) begin
            m_pos = 0;
            if (ld_i)          m_shadow = v_i;
            else if (m_pend_v) m_shadow = m_pend;
            m_pend_v = 1'b0;
         end else begin
            m_pos = m_pos + 1;
            if (ld_i) begin
               m_pend   = v_i;
               m_pend_v = 1'b1;
            end
         end
      end
   endtask

   task automatic compare(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL %s cyc%0d: scoreboard empty, observed an=%b hex=%h", tag, cycle_no, an, hex);
      end else begin
         e = exp_q.pop_front();
         vectors++;
         assert (an === e.an) else begin
            miscompares++;
            $error("FAIL %s cyc%0d an: observed %b expected %b", tag, cycle_no, an, e.an);
         end
         vectors++;
         assert (hex === e.hex) else begin
            miscompares++;
            $error("FAIL %s cyc%0d hex: observed %h expected %h", tag, cycle_no, hex, e.hex);
         end
         vectors++;
         assert (frame_done === e.fd) else begin
            miscompares++;
            $error("FAIL %s cyc%0d frame_done: observed %b expected %b", tag, cycle_no, frame_done, e.fd);
         end
      end
   endtask

   task automatic step(input string tag, input logic rst_i, input logic ld_i, input logic [15:0] v_i);
      reset = rst_i;
      load  = ld_i;
      value = v_i;
      model_edge(rst_i, ld_i, v_i);
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
      cycle_no = rst_i ? 0 : cycle_no + 1;
      reset = 1'b0;
      load  = 1'b0;
      compare(tag);
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic run_to_last(input string tag);
      while (m_pos != FRAME - 1) step(tag, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic check_live(input string tag);
      exp_q.push_back(model_out());
      #1;
      compare(tag);
   endtask

   initial begin
      reset    = 1'b1;
      load     = 1'b0;
      value    = '0;
      enable   = 1'b1;
      blank_lz = 1'b0;

      step("reset", 1'b1, 1'b0, 16'h0000);
      step("reset", 1'b1, 1'b0, 16'h0000);

      run("scan", 5);
      step("load_1a3f", 1'b0, 1'b1, 16'h1A3F);
      run("wait_commit", 10);
      run("frame2", 17);

      run_to_last("to_boundary");
      step("boundary_load", 1'b0, 1'b1, 16'h1234);
      run("after_boundary", 3);

      step("load_1111", 1'b0, 1'b1, 16'h1111);
      run("between_loads", 2);
      step("load_2222", 1'b0, 1'b1, 16'h2222);
      run_to_last("last_wins_wait");
      run("last_wins", 16);

      blank_lz = 1'b1;
      step("load_0040", 1'b0, 1'b1, 16'h0040);
      run_to_last("blank_wait");
      run("blank_0040", 14);
      blank_lz = 1'b0;
      check_live("blank_off_live");
      blank_lz = 1'b1;
      check_live("blank_on_live");
      step("load_0000", 1'b0, 1'b1, 16'h0000);
      run_to_last("blank_wait0");
      run("blank_0000", 16);

      blank_lz = 1'b0;
      enable   = 1'b0;
      run("disabled", 20);
      enable = 1'b1;
      check_live("enable_live");
      enable = 1'b0;
      check_live("disable_live");
      enable = 1'b1;

      run_to_last("pre_reset");
      run("pre_reset", 3);
      step("pend_beef", 1'b0, 1'b1, 16'hBEEF);
      while (m_pos / DC != 2) step("to_digit2", 1'b0, 1'b0, 16'h0000);
      step("mid_reset", 1'b1, 1'b0, 16'h0000);
      run("post_reset", 2 * FRAME + 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Four-digit time-multiplexing driver for the board's common-anode 7-segment display. Holds a 16-bit display word, scans one hex digit at a time at a programmable dwell rate, and drives the active-low anode enables. The current digit's nibble goes straight into the hex-to-7-segment decoder, whose segment output drives the cathodes. New values are double-buffered and committed only at frame boundaries, so a frame never mixes old and new digits.

## Interface
- DIGIT_CYCLES, 100000: clk cycles each digit stays lit (1 ms at 100 MHz). Minimum legal value is 2.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- value  in  16  display word; [3:0] is digit0 (rightmost), [15:12] is digit3 (leftmost)
- load  in  1  one-cycle strobe; captures `value` into the pending buffer
- blank_lz  in  1  leading-zero blanking enable, evaluated live
- enable  in  1  display on; when 0, all anodes are off
- hex  out  4  nibble of the currently scanned digit, to the decoder
- an  out  4  anode enables, active-low, an[i] selects digit i
- frame_done  out  1  one-cycle pulse marking the start of each new frame

## Operation
- State registers:
  - dwell counter cnt, width clog2(DIGIT_CYCLES)
  - digit index idx, 2 bits
  - shadow, 16 bits: the displayed word
  - pending, 16 bits, with flag pend_v
  - frame_done register
- Scan sequence:
  - cnt counts 0..DIGIT_CYCLES-1, then wraps to 0.
  - On each wrap, idx advances 0→1→2→3→0.
- Frame boundary is the edge where cnt==DIGIT_CYCLES-1 and idx==3. On that edge:
  - idx<=0 and cnt<=0.
  - frame_done<=1; it is 0 on every other edge.
  - If pend_v, shadow<=pending and pend_v<=0.
- load handling:
  - Ordinary edge with load=1: pending<=value and pend_v<=1.
  - Several loads in one frame: the last one wins.
  - Load on the frame-boundary edge: shadow<=value directly and pend_v<=0. Any older pending data is discarded.
- Leading-zero blanking, when blank_lz=1:
  - Digit i (i≥1) is blanked if shadow nibbles i..3 are all zero.
  - Digit0 is never blanked, so 0000 displays a single "0".
- Output decode is combinational from the registered idx/shadow plus the live enable/blank_lz:
  - Normal lit digit: an = ~(4'b0001<<idx) and hex = shadow[4*idx+:4].
  - Blanked digit: an = 4'b1111 and hex = 4'h0.
  - enable=0: an = 4'b1111 and hex = shadow nibble as usual; scanning and frame_done keep running.
- Reset (synchronous, takes priority over load): cnt, idx, shadow, pending, pend_v and frame_done all go to 0.
  - Outputs the cycle after reset, with enable=1: an=4'b1110, hex=4'h0, frame_done=0.
  - Reset mid-frame aborts the frame; any pending data is lost.

## Timing
- Each digit is lit for exactly DIGIT_CYCLES cycles; a frame is 4·DIGIT_CYCLES cycles.
- frame_done is high during the first cycle of digit0 in each frame, except the first frame after reset (no pulse).
- load→display latency: shadow updates at the next frame boundary, i.e. 1 to 4·DIGIT_CYCLES cycles. A load on the boundary edge is visible the very next cycle.
- enable and blank_lz act on an/hex in the same cycle they change (no register stage).
- No combinational path from value or load to the outputs.

## Test plan
- DIGIT_CYCLES=4, release reset, enable=1 → an is 1110×4, 1101×4, 1011×4, 0111×4, then 1110 again. frame_done=1 only on cycle 16 after reset; hex=0 throughout.
- load value=16'h1A3F at cycle 5 → hex stays 0 until cycle 16. Frame 2 then shows hex F,3,A,1 as an steps 1110,1101,1011,0111.
- Boundary and repeated loads:
  - load 16'h1234 exactly on the boundary edge → the next cycle shows an=1110, hex=4.
  - load 16'h1111 then 16'h2222 in the same frame → the next frame shows 2222.
- blank_lz=1, shadow=16'h0040 → an stays 1111 during digits 3 and 2; digit1 is lit with hex=4, digit0 lit with hex=0. With shadow=16'h0000 only digit0 is lit, hex=0.
- enable=0 for a full frame → an=1111 throughout, frame_done still pulses every 16 cycles.
- Mid-frame reset during digit2 with a pending load → after reset an=1110, hex=0, the pending value is never displayed, and the scan restarts at cnt=0.
